uart_receiver: RTL and testbench

UART serial receiver for the 100 MHz system clock domain. It is the receive-side counterpart of the UART baud clocking. It generates its own 16x oversampling enable tick from the system clock, with no derived clocks. It deframes 8N1 characters using mid-bit majority voting and presents each byte through a level valid/ack handshake, with framing-error and overrun reporting.

---
 rtl/uart_receiver.sv | 153 +++++++++++++++
 tb/tb_uart_receiver.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 16x oversampling tick generated from the system clock.
// Mid-bit 3-sample majority voting; the received byte is held under a level valid/ack handshake.
module uart_receiver #(
  parameter int unsigned SYS_CLOCK = 100_000_000
) (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic [2:0] UART_Baud_Rate_Mode_In,
  input  logic       RX_Serial_In,
  input  logic       RX_Ack_In,
  output logic [7:0] RX_Data_Out,
  output logic       RX_Valid_Out,
  output logic       RX_Frame_Error_Out,
  output logic       RX_Overrun_Out,
  output logic       RX_Busy_Out
);

  localparam int unsigned DIV_4800   = SYS_CLOCK / (16 * 4800);
  localparam int unsigned DIV_9600   = SYS_CLOCK / (16 * 9600);
  localparam int unsigned DIV_19200  = SYS_CLOCK / (16 * 19200);
  localparam int unsigned DIV_38400  = SYS_CLOCK / (16 * 38400);
  localparam int unsigned DIV_57600  = SYS_CLOCK / (16 * 57600);
  localparam int unsigned DIV_115200 = SYS_CLOCK / (16 * 115200);
  localparam int unsigned CNT_W      = $clog2(DIV_4800);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [2:0]       mode_q;
  logic             mode_change;
  logic [CNT_W-1:0] tick_cnt, tick_top;
  logic             tick;
  logic [3:0]       sub_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       samples;
  logic [7:0]       shift_reg;
  logic             fall, bit_vote, stop_vote, bit_eval, stop_eval, complete, load;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      mode_q  <= '0;
    end else begin
      rx_meta <= RX_Serial_In;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      mode_q  <= UART_Baud_Rate_Mode_In;
    end
  end

  always_comb begin
    tick_top = CNT_W'(DIV_115200 - 1);
    case (mode_q)
      3'b000:  tick_top = CNT_W'(DIV_4800 - 1);
      3'b001:  tick_top = CNT_W'(DIV_9600 - 1);
      3'b010:  tick_top = CNT_W'(DIV_19200 - 1);
      3'b011:  tick_top = CNT_W'(DIV_38400 - 1);
      3'b100:  tick_top = CNT_W'(DIV_57600 - 1);
      default: tick_top = CNT_W'(DIV_115200 - 1);
    endcase
  end

  assign mode_change = (mode_q != UART_Baud_Rate_Mode_In);
  assign fall        = rx_prev & ~rx_sync;
  assign tick        = (state != IDLE) && (tick_cnt == tick_top);
  assign bit_eval    = tick && (sub_cnt == 4'd15);
  assign bit_vote    = maj3(samples[0], samples[1], samples[2]);
  // Stop is voted at the sub-bit-9 tick, so the third sample is the live synchronized line.
  assign stop_vote   = maj3(samples[0], samples[1], rx_sync);
  assign stop_eval   = (state == STOP) && tick && (sub_cnt == 4'd9) && !mode_change;
  assign complete    = stop_eval && stop_vote;
  assign load        = complete && (!RX_Valid_Out || RX_Ack_In);

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      tick_cnt <= '0;
      sub_cnt  <= '0;
    end else if (mode_change || state == IDLE) begin
      tick_cnt <= '0;
      sub_cnt  <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      sub_cnt  <= sub_cnt + 4'd1;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      samples   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (tick && sub_cnt == 4'd7) samples[0] <= rx_sync;
      if (tick && sub_cnt == 4'd8) samples[1] <= rx_sync;
      if (tick && sub_cnt == 4'd9) samples[2] <= rx_sync;
      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (state == DATA && bit_eval) begin
        bit_idx   <= bit_idx + 3'd1;
        shift_reg <= {bit_vote, shift_reg[7:1]};
      end
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (fall) state_next = START;
      START:      if (bit_eval) state_next = bit_vote ? IDLE : DATA;
      DATA:       if (bit_eval && bit_idx == 3'd7) state_next = STOP;
      STOP:       if (tick && sub_cnt == 4'd9) state_next = stop_vote ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (rx_sync) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    if (mode_change) state_next = IDLE;
  end

  // Busy is registered from the state, so it trails the FSM by one clock.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      RX_Data_Out        <= '0;
      RX_Valid_Out       <= 1'b0;
      RX_Frame_Error_Out <= 1'b0;
      RX_Overrun_Out     <= 1'b0;
      RX_Busy_Out        <= 1'b0;
    end else begin
      RX_Frame_Error_Out <= stop_eval && !stop_vote;
      RX_Overrun_Out     <= complete && !load;
      RX_Busy_Out        <= (state != IDLE);
      if (load) begin
        RX_Data_Out  <= shift_reg;
        RX_Valid_Out <= 1'b1;
      end else if (RX_Ack_In) begin
        RX_Valid_Out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver; a 10 MHz system clock keeps frame lengths short.
// Expected bytes are queued when a frame is sent and checked when the receiver loads them.
module tb_uart_receiver;

  localparam int unsigned SYS = 10_000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'b101;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, fe, ov, busy;

  int checks = 0, errors = 0;
  int cyc = 0;
  int loads = 0, fe_cnt = 0, ov_cnt = 0, busy_hi_cnt = 0;
  int fe_cyc = 0, ov_cyc = 0, load_cyc = 0, busy_fall_cyc = 0;
  logic [7:0] exp_q[$];

  uart_receiver #(.SYS_CLOCK(SYS)) dut (
    .Clk_In(clk),
    .Reset_In(rst),
    .UART_Baud_Rate_Mode_In(mode),
    .RX_Serial_In(rx),
    .RX_Ack_In(ack),
    .RX_Data_Out(data),
    .RX_Valid_Out(valid),
    .RX_Frame_Error_Out(fe),
    .RX_Overrun_Out(ov),
    .RX_Busy_Out(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_for(input logic [2:0] m);
    int baud;
    case (m)
      3'd0:    baud = 4800;
      3'd1:    baud = 9600;
      3'd2:    baud = 19200;
      3'd3:    baud = 38400;
      3'd4:    baud = 57600;
      default: baud = 115200;
    endcase
    return SYS / (16 * baud);
  endfunction

  // Output monitor: scoreboard pops on every load, flag pulses are counted and timestamped.
  initial begin
    logic       prev_valid = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (valid && (!prev_valid || data != prev_data)) begin
        loads++;
        load_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load got %02h expected none", data);
        end else begin
          exp = exp_q.pop_front();
          if (data !== exp) begin
            errors++;
            $display("FAIL load_data got %02h expected %02h", data, exp);
          end
        end
      end
      if (fe) begin fe_cnt++; fe_cyc = cyc; end
      if (ov) begin ov_cnt++; ov_cyc = cyc; end
      if (busy) busy_hi_cnt++;
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_valid = valid;
      prev_data  = data;
      prev_busy  = busy;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    loads = 0; fe_cnt = 0; ov_cnt = 0; busy_hi_cnt = 0;
    fe_cyc = 0; ov_cyc = 0; load_cyc = 0; busy_fall_cyc = 0;
  endtask

  // Caller is at a negedge; the start bit is driven immediately.
  task automatic send_byte(input logic [7:0] d, input int bitc, input logic stop_bit);
    rx = 1'b0;
    repeat (bitc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bitc) @(negedge clk);
    end
    rx = stop_bit;
    repeat (bitc) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({data, valid, fe, ov, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %03h expected 000", {data, valid, fe, ov, busy});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({valid, fe, ov, busy} !== 4'b0000 || fe_cnt != 0 || ov_cnt != 0) begin
      errors++;
      $display("FAIL post_reset_idle got %04b fe=%0d ov=%0d expected 0000 0 0",
               {valid, fe, ov, busy}, fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_basic();
    int n = n_for(3'b101);
    int c;
    clear_counts();
    @(negedge clk);
    c = cyc;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 16 * n, 1'b1);
    checks++;
    if (exp_q.size() != 0 || loads != 1) begin
      errors++;
      $display("FAIL basic_load got loads=%0d pending=%0d expected 1 0", loads, exp_q.size());
    end
    checks++;
    if (load_cyc - c != 3 + 154 * n) begin
      errors++;
      $display("FAIL basic_latency got %0d expected %0d", load_cyc - c, 3 + 154 * n);
    end
    checks++;
    if (busy_fall_cyc != load_cyc + 1) begin
      errors++;
      $display("FAIL busy_after_valid got %0d expected %0d", busy_fall_cyc, load_cyc + 1);
    end
    ack_pulse();
    checks++;
    if (valid !== 1'b0 || fe_cnt != 0 || ov_cnt != 0) begin
      errors++;
      $display("FAIL ack_clears got valid=%b fe=%0d ov=%0d expected 0 0 0", valid, fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_false_start();
    int n = n_for(3'b101);
    clear_counts();
    @(negedge clk);
    rx = 1'b0;
    repeat (5 * n) @(negedge clk);
    rx = 1'b1;
    repeat (20 * n) @(negedge clk);
    checks++;
    if (busy_hi_cnt != 16 * n || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy got %0d cycles busy=%b expected %0d 0", busy_hi_cnt, busy, 16 * n);
    end
    checks++;
    if (loads != 0 || fe_cnt != 0 || ov_cnt != 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_quiet got loads=%0d fe=%0d ov=%0d valid=%b expected 0 0 0 0",
               loads, fe_cnt, ov_cnt, valid);
    end
  endtask

  task automatic test_frame_error();
    int n = n_for(3'b101);
    int c;
    clear_counts();
    @(negedge clk);
    c = cyc;
    send_byte(8'h3C, 16 * n, 1'b0);
    repeat (32 * n) @(negedge clk);
    checks++;
    if (fe_cnt != 1 || fe_cyc - c != 3 + 154 * n) begin
      errors++;
      $display("FAIL frame_error got width=%0d at=%0d expected 1 %0d", fe_cnt, fe_cyc - c, 3 + 154 * n);
    end
    checks++;
    if (valid !== 1'b0 || loads != 0 || ov_cnt != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL break_hold got valid=%b loads=%0d ov=%0d busy=%b expected 0 0 0 1",
               valid, loads, ov_cnt, busy);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL break_busy_late got %b expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL break_release got %b expected 0", busy);
    end
  endtask

  task automatic test_overrun();
    int n = n_for(3'b101);
    int c;
    clear_counts();
    @(negedge clk);
    exp_q.push_back(8'h11);
    send_byte(8'h11, 16 * n, 1'b1);
    c = cyc;
    send_byte(8'h22, 16 * n, 1'b1);
    checks++;
    if (ov_cnt != 1 || ov_cyc - c != 3 + 154 * n || fe_cnt != 0) begin
      errors++;
      $display("FAIL overrun_pulse got width=%0d at=%0d fe=%0d expected 1 %0d 0",
               ov_cnt, ov_cyc - c, fe_cnt, 3 + 154 * n);
    end
    checks++;
    if (data !== 8'h11 || valid !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_keeps got %02h valid=%b pending=%0d expected 11 1 0", data, valid, exp_q.size());
    end
    ack_pulse();
    clear_counts();
    exp_q.push_back(8'h11);
    send_byte(8'h11, 16 * n, 1'b1);
    exp_q.push_back(8'h22);
    c = cyc;
    fork
      send_byte(8'h22, 16 * n, 1'b1);
      begin
        repeat (2 + 154 * n) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    checks++;
    if (ov_cnt != 0 || data !== 8'h22 || valid !== 1'b1 || exp_q.size() != 0 || loads != 2) begin
      errors++;
      $display("FAIL ack_on_complete got ov=%0d data=%02h valid=%b loads=%0d expected 0 22 1 2",
               ov_cnt, data, valid, loads);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = n_for(3'b101);
    clear_counts();
    @(negedge clk);
    rx = 1'b0;
    repeat (16 * n) @(negedge clk);
    rx = 1'b1;
    repeat (72 * n) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({data, valid, fe, ov, busy} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got %03h expected 000", {data, valid, fe, ov, busy});
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (40 * n) @(negedge clk);
    checks++;
    if (fe_cnt != 0 || ov_cnt != 0 || loads != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_quiet got fe=%0d ov=%0d loads=%0d busy=%b expected 0 0 0 0",
               fe_cnt, ov_cnt, loads, busy);
    end
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 16 * n, 1'b1);
    checks++;
    if (data !== 8'h5A || valid !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_frame got %02h valid=%b expected 5a 1", data, valid);
    end
    ack_pulse();
  endtask

  task automatic test_mode_change();
    int n0 = n_for(3'b000);
    int n1 = n_for(3'b001);
    mode = 3'b000;
    repeat (10) @(negedge clk);
    clear_counts();
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 16 * n0, 1'b1);
    checks++;
    if (data !== 8'h3C || valid !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mode4800_frame got %02h valid=%b expected 3c 1", data, valid);
    end
    ack_pulse();
    clear_counts();
    rx = 1'b0;
    repeat (16 * n0) @(negedge clk);
    rx = 1'b1;
    repeat (16 * n0) @(negedge clk);
    rx = 1'b0;
    repeat (8 * n0) @(negedge clk);
    mode = 3'b001;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mode_abort_busy got %b expected 0", busy);
    end
    repeat (20 * n1) @(negedge clk);
    checks++;
    if (loads != 0 || fe_cnt != 0 || ov_cnt != 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mode_abort_quiet got loads=%0d fe=%0d ov=%0d valid=%b expected 0 0 0 0",
               loads, fe_cnt, ov_cnt, valid);
    end
    exp_q.push_back(8'h81);
    send_byte(8'h81, 16 * n1, 1'b1);
    checks++;
    if (data !== 8'h81 || valid !== 1'b1 || exp_q.size() != 0 || fe_cnt != 0) begin
      errors++;
      $display("FAIL mode9600_frame got %02h valid=%b fe=%0d expected 81 1 0", data, valid, fe_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_mode_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
